// File: rtl/cell_drawer.sv
// Per-cell rasteriser: fetches one board cell's type and paints a filled
// WIDTH x WIDTH square into the VGA pixel port, one pixel per clock.
module cell_drawer #(
   parameter int                  WIDTH    = 20,
   parameter int                  SPACING  = 5,
   parameter int                  X_OFFSET = 0,
   parameter int                  Y_OFFSET = 0,
   parameter int                  COLOUR_W = 3,
   parameter logic [COLOUR_W-1:0] C_EMPTY  = 3'b000,
   parameter logic [COLOUR_W-1:0] C_WALL   = 3'b111,
   parameter logic [COLOUR_W-1:0] C_PLAYER = 3'b010,
   parameter logic [COLOUR_W-1:0] C_GOAL   = 3'b100
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          address,
   output logic [7:0]          mem_address,
   input  logic [1:0]          mem_data,
   output logic [10:0]         x,
   output logic [10:0]         y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_DRAW = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [10:0] PITCH = 11'(WIDTH + SPACING);
   localparam logic [10:0] X_OFF = 11'(X_OFFSET);
   localparam logic [10:0] Y_OFF = 11'(Y_OFFSET);
   localparam logic [4:0]  LAST  = 5'(WIDTH - 1);

   function automatic logic [COLOUR_W-1:0] palette(input logic [1:0] cell_type);
      logic [COLOUR_W-1:0] c;
      case (cell_type)
         2'd0:    c = C_EMPTY;
         2'd1:    c = C_WALL;
         2'd2:    c = C_PLAYER;
         2'd3:    c = C_GOAL;
         default: c = C_EMPTY;
      endcase
      return c;
   endfunction

   state_t              state_q, state_d;
   logic [7:0]          mem_address_q, mem_address_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic [10:0]         ox_q, ox_d, oy_q, oy_d;
   logic [4:0]          cx_q, cx_d, cy_q, cy_d;
   logic [10:0]         x_q, x_d, y_q, y_d;
   logic                plot_q, plot_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [10:0]         origin_x_s, origin_y_s;

   // The latched address doubles as the cell position for the origin.
   assign origin_x_s = X_OFF + {7'd0, mem_address_q[3:0]} * PITCH;
   assign origin_y_s = Y_OFF + {7'd0, mem_address_q[7:4]} * PITCH;

   // Next-state and next-output logic; pixel outputs are loaded one cycle
   // ahead so the registered x/y/colour/plot appear in the DRAW cycle itself.
   always_comb begin
      state_d       = state_q;
      mem_address_d = mem_address_q;
      colour_d      = colour_q;
      ox_d          = ox_q;
      oy_d          = oy_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      x_d           = x_q;
      y_d           = y_q;
      plot_d        = 1'b0;
      done_d        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mem_address_d = address;
               state_d       = S_READ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            colour_d = palette(mem_data);
            ox_d     = origin_x_s;
            oy_d     = origin_y_s;
            cx_d     = 5'd0;
            cy_d     = 5'd0;
            x_d      = origin_x_s;
            y_d      = origin_y_s;
            plot_d   = 1'b1;
            state_d  = S_DRAW;
         end
         S_DRAW: begin
            if ((cx_q == LAST) && (cy_q == LAST)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               if (cx_q == LAST) begin
                  cx_d = 5'd0;
                  cy_d = cy_q + 5'd1;
               end else begin
                  cx_d = cx_q + 5'd1;
               end
               x_d    = ox_q + {6'd0, cx_d};
               y_d    = oy_q + {6'd0, cy_d};
               plot_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         mem_address_q <= 8'd0;
         colour_q      <= '0;
         ox_q          <= 11'd0;
         oy_q          <= 11'd0;
         cx_q          <= 5'd0;
         cy_q          <= 5'd0;
         x_q           <= 11'd0;
         y_q           <= 11'd0;
         plot_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_address_q <= mem_address_d;
         colour_q      <= colour_d;
         ox_q          <= ox_d;
         oy_q          <= oy_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         x_q           <= x_d;
         y_q           <= y_d;
         plot_q        <= plot_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign mem_address = mem_address_q;
   assign colour      = colour_q;
   assign x           = x_q;
   assign y           = y_q;
   assign plot        = plot_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_cell_drawer.sv
// Self-checking bench for cell_drawer: directed and random cells against a
// pixel-list model derived from cell position and board contents.
module tb_cell_drawer;

   localparam int W     = 20;
   localparam int PITCH = 25;
   localparam int NPIX  = W * W;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  address;
   logic [7:0]  mem_address;
   logic [1:0]  mem_data;
   logic [10:0] x;
   logic [10:0] y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        done;

   logic [1:0]  mem [256];
   int          errors = 0;
   int          checks = 0;

   cell_drawer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .address     (address),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   // Synchronous board RAM: data follows the address one clock later.
   always @(posedge clock) mem_data <= mem[mem_address];

   function automatic logic [2:0] pal(input logic [1:0] t);
      logic [2:0] c;
      case (t)
         2'd0:    c = 3'b000;
         2'd1:    c = 3'b111;
         2'd2:    c = 3'b010;
         default: c = 3'b100;
      endcase
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Draw one cell; optionally hold start high, abort by reset at a pixel
   // index, or rewrite the cell's RAM word after it has been read.
   task automatic run_draw(input logic [7:0] addr, input bit hold, input int abort_pix,
                           input bit poke_mem);
      logic [2:0] ecol;
      int ox, oy, k;
      logic [7:0] addr2;
      ecol  = pal(mem[addr]);
      ox    = int'(addr[3:0]) * PITCH;
      oy    = int'(addr[7:4]) * PITCH;
      addr2 = ~addr;
      @(negedge clock);
      address = addr;
      start   = 1'b1;
      for (int n = 1; n <= 404; n++) begin
         @(negedge clock);
         if (!hold) start = 1'b0;
         if (n == 50) begin
            address = addr2;
            if (poke_mem) mem[addr] = mem[addr] + 2'd1;
         end
         if (n <= 2) begin
            chk("pre_plot", 32'(plot), 32'd0);
            chk("pre_busy", 32'(busy), 32'd1);
            chk("pre_done", 32'(done), 32'd0);
            if (n == 1) chk("mem_address", 32'(mem_address), 32'(addr));
         end else if (n < 3 + NPIX) begin
            k = n - 3;
            chk("plot", 32'(plot), 32'd1);
            chk("x", 32'(x), 32'(ox + k % W));
            chk("y", 32'(y), 32'(oy + k / W));
            chk("colour", 32'(colour), 32'(ecol));
            chk("draw_busy", 32'(busy), 32'd1);
            chk("draw_done", 32'(done), 32'd0);
            if (abort_pix >= 0 && k == abort_pix) begin
               reset = 1'b1;
               start = 1'b0;
               @(negedge clock);
               reset = 1'b0;
               chk("rst_plot", 32'(plot), 32'd0);
               chk("rst_busy", 32'(busy), 32'd0);
               chk("rst_done", 32'(done), 32'd0);
               chk("rst_x", 32'(x), 32'd0);
               chk("rst_y", 32'(y), 32'd0);
               for (int j = 0; j < 10; j++) begin
                  @(negedge clock);
                  chk("abort_no_done", 32'(done), 32'd0);
                  chk("abort_no_plot", 32'(plot), 32'd0);
               end
               return;
            end
         end else if (n == 3 + NPIX) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_plot", 32'(plot), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
         end else begin
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_plot", 32'(plot), 32'd0);
         end
      end
      if (hold) begin
         @(negedge clock);
         start = 1'b0;
         chk("restart_busy", 32'(busy), 32'd1);
         chk("restart_addr", 32'(mem_address), 32'(addr2));
         begin
            int lat;
            lat = 0;
            for (int i = 1; i <= 500; i++) begin
               @(negedge clock);
               if (done) begin
                  lat = i;
                  break;
               end
            end
            chk("restart_latency", 32'(lat), 32'(NPIX + 2));
         end
         @(negedge clock);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 2'($urandom_range(0, 3));
      mem[8'h00] = 2'd1;
      mem[8'h11] = 2'd2;
      mem[8'hFF] = 2'd3;
      mem[8'h37] = 2'd0;
      reset   = 1'b1;
      start   = 1'b0;
      address = 8'd0;
      repeat (3) @(negedge clock);
      chk("reset_plot", 32'(plot), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_x", 32'(x), 32'd0);
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_colour", 32'(colour), 32'd0);
      chk("reset_memaddr", 32'(mem_address), 32'd0);
      reset = 1'b0;

      run_draw(8'h00, 1'b0, -1, 1'b0);
      run_draw(8'h11, 1'b0, -1, 1'b0);
      run_draw(8'hFF, 1'b0, -1, 1'b0);
      run_draw(8'h37, 1'b0, -1, 1'b1);
      run_draw(8'h5A, 1'b1, -1, 1'b0);
      run_draw(8'h23, 1'b0, 100, 1'b0);
      run_draw(8'h23, 1'b0, -1, 1'b0);
      for (int r = 0; r < 4; r++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 255));
         run_draw(a, 1'b0, -1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
